// File: rtl/multiword_add_seq_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
package multiword_add_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Word index counter width; a single-word build still needs one bit.
    function automatic int unsigned idx_width(input int unsigned words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/word_adder_cin.sv
// N-bit ripple-carry word adder with carry-in; exposes the carry into the MSB
// so the sequencer can derive two's-complement overflow on the top word.
module word_adder_cin #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic carry;

    always_comb begin
        carry = cin;
        c_msb = 1'b0;
        s     = '0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) c_msb = carry;
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Wide add/subtract sequencer: streams operand words LSW-first through one
// shared N-bit adder, chaining the carry and collecting the result.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic [N*WORDS-1:0]   a_in,
    input  logic [N*WORDS-1:0]   b_in,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   sum,
    output logic                 carry_out,
    output logic                 overflow
);

    localparam int unsigned W     = N * WORDS;
    localparam int unsigned IDX_W = idx_width(WORDS);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic [N-1:0]     a_word_c, b_word_c, s_word_c;
    logic             cout_c, c_msb_c, last_c;

    // Select the operand word currently being processed.
    always_comb begin
        a_word_c = '0;
        b_word_c = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_word_c = a_q[k*N +: N];
                b_word_c = b_q[k*N +: N];
            end
        end
    end

    assign last_c = (idx_q == IDX_W'(WORDS - 1));

    word_adder_cin #(.N(N)) u_word_adder (
        .a     (a_word_c),
        .b     (b_word_c),
        .cin   (carry_q),
        .s     (s_word_c),
        .cout  (cout_c),
        .c_msb (c_msb_c)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        ready_d     = ready_q;
        busy_d      = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
                    a_d         = a_in;
                    b_d         = op_sub ? ~b_in : b_in;
                    carry_d     = op_sub;
                    idx_d       = '0;
                    sum_d       = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = ST_RUN;
                    ready_d     = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_RUN: begin
                for (int k = 0; k < WORDS; k++) begin
                    if (idx_q == IDX_W'(k)) sum_d[k*N +: N] = s_word_c;
                end
                carry_d = cout_c;
                idx_d   = idx_q + IDX_W'(1);
                if (last_c) begin
                    carry_out_d = cout_c;
                    overflow_d  = c_msb_c ^ cout_c;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                    ready_d     = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule
